muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, beside the ALU; owns the HI/LO register pair.

---
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO pair; one step per cycle, DATA_W steps per op.
// Optional signed handling (op[0]) is enabled by defining MULDIV_SIGNED_EN; the default build is unsigned-only.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_busy, r_done, r_div;
  logic [DATA_W:0]     r_ph;
  logic [DATA_W-1:0]   r_pl, r_m, r_hi, r_lo;

  logic [DATA_W:0]     w_sum, w_shl, w_nph;
  logic [DATA_W-1:0]   w_npl, w_abs_a, w_abs_b, w_quo, w_rem, w_res_hi, w_res_lo;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_ge;

`ifdef MULDIV_SIGNED_EN
  logic r_neg_q, r_neg_r;
  assign w_abs_a = (op[0] && A[DATA_W-1]) ? -A : A;
  assign w_abs_b = (op[0] && B[DATA_W-1]) ? -B : B;
`else
  logic w_unused_op0;
  assign w_unused_op0 = op[0];
  assign w_abs_a = A;
  assign w_abs_b = B;
`endif

  // r_pl holds the multiplier (mult) or the dividend shifting into the quotient (div).
  always_comb begin
    w_sum = {1'b0, r_ph[DATA_W-1:0]} + (r_pl[0] ? {1'b0, r_m} : '0);
    w_shl = {r_ph[DATA_W-1:0], r_pl[DATA_W-1]};
    w_ge  = (w_shl >= {1'b0, r_m});
    if (r_div) begin
      w_nph = w_ge ? (w_shl - {1'b0, r_m}) : w_shl;
      w_npl = {r_pl[DATA_W-2:0], w_ge};
    end else begin
      w_nph = {1'b0, w_sum[DATA_W:1]};
      w_npl = {w_sum[0], r_pl[DATA_W-1:1]};
    end
    w_prod = {w_nph[DATA_W-1:0], w_npl};
    w_quo  = w_npl;
    w_rem  = w_nph[DATA_W-1:0];
`ifdef MULDIV_SIGNED_EN
    if (r_neg_q) begin
      w_prod = -w_prod;
      w_quo  = -w_quo;
    end
    if (r_neg_r) w_rem = -w_rem;
`endif
    w_res_hi = r_div ? w_rem : w_prod[2*DATA_W-1:DATA_W];
    w_res_lo = r_div ? w_quo : w_prod[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div   <= 1'b0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULDIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= op[1];
            r_ph    <= '0;
            r_pl    <= op[1] ? w_abs_a : w_abs_b;
            r_m     <= op[1] ? w_abs_b : w_abs_a;
`ifdef MULDIV_SIGNED_EN
            r_neg_q <= op[0] & (A[DATA_W-1] ^ B[DATA_W-1]);
            r_neg_r <= op[0] & A[DATA_W-1];
`endif
          end
        end
        S_RUN: begin
          r_ph  <= w_nph;
          r_pl  <= w_npl;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at start, popped and checked on done.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0, B = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cur_hi = '0, cur_lo = '0;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic sgn;
        longint sa, sb_, q, m;
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb_ = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o[1]) begin
            p = 64'(sa * sb_);
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == 32'd0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
        end else begin
            q = sa / sb_;
            m = sa % sb_;
            r.lo = q[31:0];
            r.hi = m[31:0];
        end
        return r;
    endfunction

    // inj: at cycle 10 of the run, fire a second start plus MTHI/MTLO that must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input res_t exp, input bit inj);
        int lat;
        res_t e;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0; A = $urandom; B = $urandom; op = ~o;
        lat = 1;
        forever begin
            @(negedge clk);
            if (done || lat >= 100) break;
            if (lat == 10) chk("busy_mid", busy, 1'b1);
            if (inj && lat == 12) chk("hi_hold", hi, cur_hi);
            @(posedge clk);
            lat++;
            #1;
            if (inj && lat == 10) begin
                start = 1'b1; op = 2'b00; A = 32'd3; B = 32'd3;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
        end
        chk("done_seen", done, 1'b1);
        chk("latency", lat, 33);
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        cur_hi = e.hi;
        cur_lo = e.lo;
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        res_t e;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst = 1'b0;

        e.hi = 32'h0000_0001; e.lo = 32'hFFFF_FFFE;
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, e, 1'b0);

`ifdef MULDIV_SIGNED_EN
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFF1;
`else
        e.hi = 32'h0000_0004; e.lo = 32'hFFFF_FFF1;
`endif
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, e, 1'b0);

        e.hi = 32'd2; e.lo = 32'd14;
        run_op(2'b10, 32'd100, 32'd7, e, 1'b0);

`ifdef MULDIV_SIGNED_EN
        e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFD;
`else
        e.hi = 32'h0000_0001; e.lo = 32'h7FFF_FFFC;
`endif
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, e, 1'b0);

        e.hi = 32'h1234; e.lo = 32'hFFFF_FFFF;
        run_op(2'b10, 32'h1234, 32'd0, e, 1'b0);

`ifdef MULDIV_SIGNED_EN
        e.hi = 32'h0; e.lo = 32'h8000_0000;
`else
        e.hi = 32'h8000_0000; e.lo = 32'h0;
`endif
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, e, 1'b0);

        e.hi = 32'd0; e.lo = 32'd56;
        run_op(2'b00, 32'd7, 32'd8, e, 1'b1);

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hAB;
        @(posedge clk);
        #1 hi_we = 1'b0;
        @(negedge clk);
        chk("mthi", hi, 32'hAB);
        chk("mthi_lo_kept", lo, cur_lo);
        cur_hi = 32'hAB;

        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hCD;
        @(posedge clk);
        #1 lo_we = 1'b0;
        @(negedge clk);
        chk("mtlo", lo, 32'hCD);
        chk("mtlo_hi_kept", hi, cur_hi);

        @(negedge clk);
        op = 2'b10; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cur_hi = '0; cur_lo = '0;
        e.hi = 32'd1; e.lo = 32'd333;
        run_op(2'b10, 32'd1000, 32'd3, e, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom | 32'h1;
            run_op(ro, ra, rb, model(ro, ra, rb), 1'b0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
